// File: rtl/eba_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : eba_issue_stage
// Purpose : Registered operand issue / result collect stage for the 8-bit eba
//           adder with a show-ahead result FIFO. Optional accumulator-as-B
//           feature is built when the macro EBA_ACC_EN is defined.
// Revision: 1.0
// ============================================================================
module eba_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  input  logic          in_cin,
  input  logic          in_acc,
  input  logic          acc_clr,
  output logic          a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8,
  output logic          b_1, b_2, b_3, b_4, b_5, b_6, b_7, b_8,
  output logic          cin,
  input  logic          s_1, s_2, s_3, s_4, s_5, s_6, s_7, s_8,
  input  logic          cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_sum,
  output logic          out_cout,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            w_full, w_push, w_pop;
  logic [7:0]      w_b_sel;
  logic [8:0]      w_res;

  // Adder result packed as {sum[7:0], carry}
  assign w_res  = {s_1, s_2, s_3, s_4, s_5, s_6, s_7, s_8, cout};
  assign w_full = (cnt_q == CW'(DEPTH));
  assign w_pop  = out_valid & out_ready;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (cnt_q != '0);
  assign out_sum    = out_valid ? mem_q[rd_q][8:1] : 8'h00;
  assign out_cout   = out_valid ? mem_q[rd_q][0]   : 1'b0;
  assign fifo_count = cnt_q;

  assign {a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8} = a_q;
  assign {b_1, b_2, b_3, b_4, b_5, b_6, b_7, b_8} = b_q;
  assign cin = cin_q;

`ifdef EBA_ACC_EN
  logic [7:0] acc_q;

  // Clear takes priority over the push update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
    end else if (acc_clr) begin
      acc_q <= 8'h00;
    end else if (w_push) begin
      acc_q <= w_res[8:1];
    end
  end

  assign w_b_sel = in_acc ? acc_q : in_b;
`else
  logic w_unused_acc;
  assign w_unused_acc = in_acc ^ acc_clr;
  assign w_b_sel      = in_b;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    w_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = w_b_sel;
          cin_d   = in_cin;
          state_d = DRIVE;
        end
      end
      DRIVE, HOLD: begin
        // A same-edge pop frees the slot even when the FIFO is full
        if (!w_full || w_pop) begin
          w_push  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_q] <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + AW'(1);
      if (w_pop)  rd_q <= rd_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eba_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_eba_issue_stage
// Purpose : Directed, table-driven bench for eba_issue_stage with a
//           behavioural 8-bit adder closing the loop.
// Revision: 1.0
// ============================================================================
module tb_eba_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_cin, in_acc, acc_clr;
  logic [7:0] in_a, in_b;
  logic       a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8;
  logic       b_1, b_2, b_3, b_4, b_5, b_6, b_7, b_8;
  logic       cin;
  logic       s_1, s_2, s_3, s_4, s_5, s_6, s_7, s_8;
  logic       cout;
  logic       out_valid, out_ready, out_cout;
  logic [7:0] out_sum;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eba_issue_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .in_acc(in_acc), .acc_clr(acc_clr),
    .a_1(a_1), .a_2(a_2), .a_3(a_3), .a_4(a_4),
    .a_5(a_5), .a_6(a_6), .a_7(a_7), .a_8(a_8),
    .b_1(b_1), .b_2(b_2), .b_3(b_3), .b_4(b_4),
    .b_5(b_5), .b_6(b_6), .b_7(b_7), .b_8(b_8),
    .cin(cin),
    .s_1(s_1), .s_2(s_2), .s_3(s_3), .s_4(s_4),
    .s_5(s_5), .s_6(s_6), .s_7(s_7), .s_8(s_8),
    .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .fifo_count(fifo_count)
  );

  // External adder: a_1/b_1/s_1 are the MSBs
  logic [7:0] a_bus, b_bus;
  assign a_bus = {a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8};
  assign b_bus = {b_1, b_2, b_3, b_4, b_5, b_6, b_7, b_8};
  assign {cout, s_1, s_2, s_3, s_4, s_5, s_6, s_7, s_8} =
         {1'b0, a_bus} + {1'b0, b_bus} + {8'h00, cin};

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] sum;
    logic       co;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({nm, ".ready"}, in_ready, 1);
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c, input logic acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_acc   = acc;
    tick();
    in_valid = 1'b0;
    in_acc   = 1'b0;
  endtask

  // One isolated operation: accept, check drive, check result, pop
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic acc, input logic clr,
                        input logic [7:0] eb, input logic [7:0] esum, input logic eco);
    wait_ready(nm);
    accept(a, b, c, acc);
    chk({nm, ".a_bus"}, a_bus, a);
    chk({nm, ".b_bus"}, b_bus, eb);
    chk({nm, ".cin"}, cin, c);
    chk({nm, ".in_ready_low"}, in_ready, 0);
    chk({nm, ".valid_early"}, out_valid, 0);
    acc_clr = clr;
    tick();
    acc_clr = 1'b0;
    chk({nm, ".out_valid"}, out_valid, 1);
    chk({nm, ".out_sum"}, out_sum, esum);
    chk({nm, ".out_cout"}, out_cout, eco);
    chk({nm, ".count"}, fifo_count, 1);
    chk({nm, ".in_ready_back"}, in_ready, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, ".drained"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
    vecs[1] = '{8'h02, 8'h04, 1'b1, 8'h07, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    in_cin = 1'b0; in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    #23;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.count", fifo_count, 0);
    chk("rst.out_sum", out_sum, 0);
    chk("rst.out_cout", out_cout, 0);
    chk("rst.drive", {a_bus, b_bus, cin}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, 1'b0,
             vecs[i].b, vecs[i].sum, vecs[i].co);
    end
    chk("bitorder.a_7", a_7, 0);
    chk("bitorder.b_1", b_1, 0);

    // Fill: four pushes then the fifth stalls in HOLD
    for (int k = 1; k <= 5; k++) begin
      wait_ready($sformatf("fill%0d", k));
      accept(8'(k), 8'h00, 1'b0, 1'b0);
    end
    tick();
    tick();
    chk("full.count", fifo_count, 4);
    chk("full.in_ready", in_ready, 0);
    chk("full.a_bus", a_bus, 5);
    chk("full.head", out_sum, 1);
    out_ready = 1'b1;
    tick();
    chk("drain.push_pop_count", fifo_count, 4);
    chk("drain.in_ready", in_ready, 1);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("drain.sum%0d", k), out_sum, k);
      chk($sformatf("drain.valid%0d", k), out_valid, 1);
      chk($sformatf("drain.count%0d", k), fifo_count, 6 - k);
      tick();
    end
    chk("drain.empty", out_valid, 0);
    chk("drain.count0", fifo_count, 0);
    out_ready = 1'b0;

    // Reset while DRIVE with two entries queued
    run_op("pre", 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h22, 8'h33, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_ready("q");
      accept(8'h40, 8'h01, 1'b1, 1'b0);
      tick();
    end
    wait_ready("q3");
    accept(8'h7F, 8'h7F, 1'b1, 1'b0);
    chk("midrst.pre_count", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.count", fifo_count, 0);
    chk("midrst.drive", {a_bus, b_bus, cin}, 0);
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_sum", out_sum, 0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("postrst.out_valid", out_valid, 0);
    chk("postrst.count", fifo_count, 0);

    // Accumulator sequence; clear is raised at the third push edge
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
`ifdef EBA_ACC_EN
    run_op("acc1", 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0);
    run_op("acc2", 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 8'h0A, 1'b0);
    run_op("acc3", 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0A, 8'h0F, 1'b0);
    run_op("acc4", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
`else
    run_op("acc1", 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0);
    run_op("acc2", 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0);
    run_op("acc3", 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 1'b0);
    run_op("acc4", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
